gpu_sequencer: RTL and testbench

Parametrised multi-core program sequencer for the GPU. It fetches 32-bit instructions from a synchronous program BRAM, executes scalar control instructions against its own private register file, and broadcasts work commands to CORE_COUNT shader cores with a valid/ready handshake and barrier synchronisation. It replaces the single-stream controller as the top-level issue unit.

---
 rtl/gpu_sequencer_if.sv | 34 +++
 rtl/gpu_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_gpu_sequencer.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/gpu_sequencer_if.sv
// Purpose: program-BRAM and core broadcast bus between the sequencer and its fabric.
// Latency: none (wires only); BRAM data is expected two cycles after the address.
// Backpressure: the command valid is held until every bit of core_ready_in is set.
interface gpu_sequencer_if #(
    parameter int ADDR_W     = 3,
    parameter int CORE_COUNT = 4
);
    logic [ADDR_W-1:0]     instr_addr_out;
    logic [31:0]           instr_in;
    logic                  cmd_valid_out;
    logic [27:0]           cmd_out;
    logic [CORE_COUNT-1:0] core_ready_in;
    logic [CORE_COUNT-1:0] core_idle_in;

    // Sequencer side.
    modport master (
        output instr_addr_out,
        output cmd_valid_out,
        output cmd_out,
        input  instr_in,
        input  core_ready_in,
        input  core_idle_in
    );

    // BRAM / core side.
    modport slave (
        input  instr_addr_out,
        input  cmd_valid_out,
        input  cmd_out,
        output instr_in,
        output core_ready_in,
        output core_idle_in
    );
endinterface

// File: rtl/gpu_sequencer.sv
// Purpose: fetch/execute program sequencer broadcasting work commands to shader cores.
// Latency: 3 cycles per non-stalling instruction (FETCH, WAIT, EXEC).
// Backpressure: DISPATCH holds until all cores are ready; SYNC stalls until all cores are idle.
module gpu_sequencer #(
    parameter int PRIVATE_REG_WIDTH = 10,
    parameter int PRIVATE_REG_COUNT = 16,
    parameter int INSTRUCTION_WIDTH = 32,
    parameter int INSTRUCTION_COUNT = 8,
    parameter int CORE_COUNT        = 4,
    localparam int ADDR_W           = $clog2(INSTRUCTION_COUNT)
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              start_in,
    gpu_sequencer_if.master   bus,
    output logic [ADDR_W-1:0] pc_out,
    output logic              busy_out,
    output logic              done_out,
    output logic              error_out,
    output logic [15:0]       retired_out
);
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_WAIT, S_EXEC, S_DISPATCH, S_SYNC, S_HALT
    } state_t;

    localparam logic [3:0] OP_NOP      = 4'h0;
    localparam logic [3:0] OP_LOADI    = 4'h1;
    localparam logic [3:0] OP_ADDI     = 4'h2;
    localparam logic [3:0] OP_LOOP     = 4'h3;
    localparam logic [3:0] OP_DISPATCH = 4'h4;
    localparam logic [3:0] OP_SYNC     = 4'h5;
    localparam logic [3:0] OP_HALT     = 4'hF;

    localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(INSTRUCTION_COUNT - 1);

    state_t                       state_q, state_d;
    logic [ADDR_W-1:0]            pc_q, pc_d;
    logic [PRIVATE_REG_WIDTH-1:0] regs_q [PRIVATE_REG_COUNT];
    logic [PRIVATE_REG_WIDTH-1:0] regs_d [PRIVATE_REG_COUNT];
    logic [15:0]                  retired_q, retired_d;
    logic                         error_q, error_d;
    logic [27:0]                  cmd_q, cmd_d;

    logic [INSTRUCTION_WIDTH-1:0] instr;
    logic [3:0]                   opcode;
    logic [3:0]                   rd;
    logic [PRIVATE_REG_WIDTH-1:0] imm;
    logic [ADDR_W-1:0]            target;
    logic [PRIVATE_REG_WIDTH-1:0] loop_val;
    logic [CORE_COUNT-1:0]        ready_vec;
    logic [CORE_COUNT-1:0]        idle_vec;
    logic                         rd_bad, tgt_bad, bad;
    logic                         retire, advance;

    assign instr     = bus.instr_in;
    assign opcode    = instr[31:28];
    assign rd        = instr[27:24];
    assign imm       = instr[PRIVATE_REG_WIDTH-1:0];
    assign target    = instr[ADDR_W-1:0];
    assign loop_val  = regs_q[rd] - PRIVATE_REG_WIDTH'(1);
    assign ready_vec = bus.core_ready_in;
    assign idle_vec  = bus.core_idle_in;

    // Operand range checks are done in 32 bits so they stay valid for any parameter set.
    assign rd_bad  = ({28'd0, rd} >= 32'(PRIVATE_REG_COUNT));
    assign tgt_bad = ({{(32 - ADDR_W){1'b0}}, target} >= 32'(INSTRUCTION_COUNT));

    // Decode-time legality of the instruction currently on the BRAM bus.
    always_comb begin
        bad = 1'b0;
        case (opcode)
            OP_NOP, OP_DISPATCH, OP_SYNC, OP_HALT: bad = 1'b0;
            OP_LOADI, OP_ADDI:                     bad = rd_bad;
            OP_LOOP:                               bad = rd_bad | tgt_bad;
            default:                               bad = 1'b1;
        endcase
    end

    // Next-state, register-file, pc and retirement logic.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        regs_d    = regs_q;
        retired_d = retired_q;
        error_d   = error_q;
        cmd_d     = cmd_q;
        retire    = 1'b0;
        advance   = 1'b0;

        case (state_q)
            S_IDLE, S_HALT: begin
                if (start_in) begin
                    state_d   = S_FETCH;
                    pc_d      = '0;
                    retired_d = '0;
                    error_d   = 1'b0;
                    for (int i = 0; i < PRIVATE_REG_COUNT; i++) regs_d[i] = '0;
                end
            end
            S_FETCH: state_d = S_WAIT;
            S_WAIT:  state_d = S_EXEC;
            S_EXEC: begin
                if (bad) begin
                    error_d = 1'b1;
                    state_d = S_HALT;
                end else begin
                    case (opcode)
                        OP_LOADI: begin
                            regs_d[rd] = imm;
                            advance    = 1'b1;
                        end
                        OP_ADDI: begin
                            regs_d[rd] = regs_q[rd] + imm;
                            advance    = 1'b1;
                        end
                        OP_LOOP: begin
                            regs_d[rd] = loop_val;
                            if (loop_val != '0) begin
                                retire  = 1'b1;
                                pc_d    = target;
                                state_d = S_FETCH;
                            end else begin
                                advance = 1'b1;
                            end
                        end
                        OP_DISPATCH: begin
                            cmd_d   = instr[27:0];
                            state_d = S_DISPATCH;
                        end
                        OP_SYNC: state_d = S_SYNC;
                        OP_HALT: begin
                            retire  = 1'b1;
                            state_d = S_HALT;
                        end
                        default: advance = 1'b1;  // NOP; illegal opcodes are caught by bad
                    endcase
                end
            end
            S_DISPATCH: if (&ready_vec) advance = 1'b1;
            S_SYNC:     if (&idle_vec)  advance = 1'b1;
            default:    state_d = S_IDLE;
        endcase

        // Sequential completion: the last slot halts instead of wrapping the pc.
        if (advance) begin
            retire = 1'b1;
            if (pc_q == LAST_PC) begin
                state_d = S_HALT;
            end else begin
                pc_d    = pc_q + ADDR_W'(1);
                state_d = S_FETCH;
            end
        end

        if (retire && (retired_q != 16'hFFFF)) retired_d = retired_q + 16'd1;
    end

    // State registers; reset returns to IDLE immediately, dropping any pending command.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            retired_q <= '0;
            error_q   <= 1'b0;
            cmd_q     <= '0;
            for (int i = 0; i < PRIVATE_REG_COUNT; i++) regs_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            retired_q <= retired_d;
            error_q   <= error_d;
            cmd_q     <= cmd_d;
            regs_q    <= regs_d;
        end
    end

    // The pc register drives the BRAM directly; it only changes on the edge leaving
    // EXEC/DISPATCH/SYNC, so the address is stable from FETCH through EXEC.
    assign bus.instr_addr_out = pc_q;
    assign bus.cmd_valid_out  = (state_q == S_DISPATCH);
    assign bus.cmd_out        = cmd_q;
    assign pc_out             = pc_q;
    assign busy_out           = (state_q == S_FETCH) || (state_q == S_WAIT) ||
                                (state_q == S_EXEC)  || (state_q == S_DISPATCH) ||
                                (state_q == S_SYNC);
    assign done_out           = (state_q == S_HALT) && !error_q;
    assign error_out          = error_q;
    assign retired_out        = retired_q;
endmodule

// File: tb/tb_gpu_sequencer.sv
// Purpose: self-checking bench for gpu_sequencer with a 2-cycle BRAM model and a command scoreboard.
// Latency: expected commands are queued at program load and popped on each observed transfer.
// Backpressure: core_ready_in/core_idle_in are driven per test to exercise stalls.
module tb_gpu_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  pc;
    logic        busy, done, error;
    logic [15:0] retired;

    always #5 clk = ~clk;

    gpu_sequencer_if #(.ADDR_W(3), .CORE_COUNT(4)) bus ();

    gpu_sequencer #(
        .PRIVATE_REG_WIDTH(10),
        .PRIVATE_REG_COUNT(16),
        .INSTRUCTION_WIDTH(32),
        .INSTRUCTION_COUNT(8),
        .CORE_COUNT(4)
    ) dut (
        .clk_in     (clk),
        .rst_in     (rst),
        .start_in   (start),
        .bus        (bus),
        .pc_out     (pc),
        .busy_out   (busy),
        .done_out   (done),
        .error_out  (error),
        .retired_out(retired)
    );

    // Program memory with two register stages: data appears two cycles after the address.
    logic [31:0] mem [8];
    logic [31:0] bram_s1;
    always @(posedge clk) begin
        bram_s1      <= mem[bus.instr_addr_out];
        bus.instr_in <= bram_s1;
    end

    int n_chk = 0;
    int n_pass = 0;
    int n_xfer = 0;
    int n_vld_cyc = 0;
    logic [27:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [31:0] enc(input logic [3:0] op, input logic [3:0] rd, input logic [23:0] low);
        return {op, rd, low};
    endfunction

    // Transfer monitor: sampled mid-cycle, a valid with all-ready transfers on the next edge.
    always @(negedge clk) begin
        if (!rst && bus.cmd_valid_out) begin
            n_vld_cyc++;
            if (&bus.core_ready_in) begin
                n_xfer++;
                if (exp_q.size() == 0) chk("xfer_unexpected", 32'(exp_q.size()), 32'd1);
                else chk("cmd_xfer", 32'(bus.cmd_out), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic load_nops();
        for (int i = 0; i < 8; i++) mem[i] = 32'h0;
    endtask

    // Leaves the caller 1 ns after edge 0 (the edge that samples start).
    task automatic run_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_halt(input int budget);
        int i = 0;
        while (!(done || error) && i < budget) begin
            @(posedge clk); #1;
            i++;
        end
        chk("halt_reached", 32'(done | error), 32'd1);
    endtask

    task automatic wait_valid(input int budget);
        int i = 0;
        while (!bus.cmd_valid_out && i < budget) begin
            @(posedge clk); #1;
            i++;
        end
        chk("dispatch_seen", 32'(bus.cmd_valid_out), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int bad_hold;
        int x0;
        bus.core_ready_in = 4'b1111;
        bus.core_idle_in  = 4'b1111;
        load_nops();
        rst = 1'b1;
        #12 rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_retired", 32'(retired), 32'd0);
        chk("rst_cmd_valid", 32'(bus.cmd_valid_out), 32'd0);

        // Eight NOPs fall off the end after 24 cycles.
        run_start();
        repeat (23) @(posedge clk);
        #1 chk("nop_done_early", 32'(done), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("nop_done", 32'(done), 32'd1);
        chk("nop_retired", 32'(retired), 32'd8);
        chk("nop_error", 32'(error), 32'd0);
        chk("nop_busy", 32'(busy), 32'd0);

        // Counted loop: r1 = 3, r2 incremented three times.
        load_nops();
        mem[0] = enc(4'h1, 4'd1, 24'd3);
        mem[1] = enc(4'h2, 4'd2, 24'd1);
        mem[2] = enc(4'h3, 4'd1, 24'd1);
        mem[3] = enc(4'hF, 4'd0, 24'd0);
        run_start();
        wait_halt(200);
        chk("loop_r1", 32'(dut.regs_q[1]), 32'd0);
        chk("loop_r2", 32'(dut.regs_q[2]), 32'd3);
        chk("loop_retired", 32'(retired), 32'd8);
        chk("loop_done", 32'(done), 32'd1);

        // Dispatch with partial ready for five cycles.
        load_nops();
        mem[0] = {4'h4, 28'h0ABCDEF};
        mem[1] = enc(4'hF, 4'd0, 24'd0);
        bus.core_ready_in = 4'b0111;
        n_vld_cyc = 0;
        x0 = n_xfer;
        exp_q.push_back(28'h0ABCDEF);
        run_start();
        wait_valid(50);
        bad_hold = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (!bus.cmd_valid_out || bus.cmd_out != 28'h0ABCDEF) bad_hold++;
        end
        chk("dispatch_hold", 32'(bad_hold), 32'd0);
        bus.core_ready_in = 4'b1111;
        wait_halt(50);
        chk("dispatch_vld_cycles", 32'(n_vld_cyc), 32'd6);
        chk("dispatch_xfers", 32'(n_xfer - x0), 32'd1);
        chk("dispatch_retired", 32'(retired), 32'd2);

        // SYNC stalls while any core is busy.
        load_nops();
        mem[0] = enc(4'h5, 4'd0, 24'd0);
        mem[1] = enc(4'hF, 4'd0, 24'd0);
        bus.core_idle_in = 4'b1011;
        run_start();
        repeat (12) @(posedge clk);
        #1;
        chk("sync_pc_hold", 32'(pc), 32'd0);
        chk("sync_busy", 32'(busy), 32'd1);
        chk("sync_retired_hold", 32'(retired), 32'd0);
        bus.core_idle_in = 4'b1111;
        @(posedge clk); #1;
        chk("sync_pc_adv", 32'(pc), 32'd1);
        chk("sync_retired_adv", 32'(retired), 32'd1);
        wait_halt(50);
        chk("sync_done", 32'(done), 32'd1);

        // Illegal opcode at pc 2, then a rerun clears the error first.
        load_nops();
        mem[2] = enc(4'hA, 4'd0, 24'd0);
        mem[3] = enc(4'hF, 4'd0, 24'd0);
        run_start();
        wait_halt(100);
        chk("err_flag", 32'(error), 32'd1);
        chk("err_done", 32'(done), 32'd0);
        chk("err_retired", 32'(retired), 32'd2);
        chk("err_pc", 32'(pc), 32'd2);
        run_start();
        chk("err_cleared", 32'(error), 32'd0);
        chk("err_rerun_busy", 32'(busy), 32'd1);
        wait_halt(100);
        chk("err_again", 32'(error), 32'd1);
        chk("err_again_retired", 32'(retired), 32'd2);

        // Reset in the middle of a stalled dispatch: no transfer may appear.
        load_nops();
        mem[0] = {4'h4, 28'h1234567};
        mem[1] = enc(4'hF, 4'd0, 24'd0);
        bus.core_ready_in = 4'b0011;
        x0 = n_xfer;
        run_start();
        wait_valid(50);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("rst_mid_valid", 32'(bus.cmd_valid_out), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_retired", 32'(retired), 32'd0);
        chk("rst_mid_cmd", 32'(bus.cmd_out), 32'd0);
        #1 rst = 1'b0;
        bus.core_ready_in = 4'b1111;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mid_idle", 32'(busy), 32'd0);
        chk("rst_mid_xfers", 32'(n_xfer - x0), 32'd0);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
